// File: rtl/mem_resp_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_unit_pkg
// Shared definitions for the memory response path: default bus widths, the
// response record carried through the output queue, and the occupancy
// encoding of the 2-entry response queue.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_resp_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned TAG_WIDTH_DEF  = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 8;

  // Response record at the default widths
  typedef struct packed {
    logic [TAG_WIDTH_DEF-1:0]  addr;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      error;
  } resp_t;

  // Output queue occupancy states
  localparam logic [1:0] Q_EMPTY = 2'd0;
  localparam logic [1:0] Q_ONE   = 2'd1;
  localparam logic [1:0] Q_TWO   = 2'd2;

endpackage

// File: rtl/mem_resp_unit_if.sv
// -----------------------------------------------------------------------------
// mem_resp_unit_if
// Bundles the three channels around the response unit:
//   memory response : mem_rvalid/mem_rready/mem_rdata/mem_rerror
//   address buffer  : buf_rena/buf_rdata/buf_valid/buf_empty
//   output consumer : out_valid/out_ready/out_addr/out_data/out_error
// Modports:
//   slave  - the response unit's view
//   master - the surrounding environment's view (memory, buffer, consumer)
// -----------------------------------------------------------------------------
interface mem_resp_unit_if
  import mem_resp_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEF
);

  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rerror;

  logic                  buf_rena;
  logic [TAG_WIDTH-1:0]  buf_rdata;
  logic                  buf_valid;
  logic                  buf_empty;

  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_WIDTH-1:0]  out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_error;

  modport slave (
    input  mem_rvalid, mem_rdata, mem_rerror,
    output mem_rready,
    input  buf_rdata, buf_valid, buf_empty,
    output buf_rena,
    input  out_ready,
    output out_valid, out_addr, out_data, out_error
  );

  modport master (
    output mem_rvalid, mem_rdata, mem_rerror,
    input  mem_rready,
    output buf_rdata, buf_valid, buf_empty,
    input  buf_rena,
    output out_ready,
    input  out_valid, out_addr, out_data, out_error
  );

endinterface

// File: rtl/mem_resp_unit_resp_queue.sv
// -----------------------------------------------------------------------------
// mem_resp_unit_resp_queue
// 2-entry registered FIFO of response records. Slot 0 is always the head and
// drives the output directly from a register; slot 1 shifts into slot 0 when
// the head is consumed.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   i_clear          - synchronous clear of the occupancy (flush)
//   i_in_valid       - enqueue request (honoured only while o_in_ready)
//   o_in_ready       - space available, from registered occupancy only
//   i_in_data        - record to enqueue
//   o_out_valid      - head valid (registered)
//   i_out_ready      - consumer takes the head
//   o_out_data       - head record (registered)
// -----------------------------------------------------------------------------
module mem_resp_unit_resp_queue
  import mem_resp_unit_pkg::*;
#(
  parameter type T = resp_t
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_in_valid,
  output logic o_in_ready,
  input  T     i_in_data,
  output logic o_out_valid,
  input  logic i_out_ready,
  output T     o_out_data
);

  logic [1:0] r_count;
  logic       r_out_valid;
  T           r_slot0;
  T           r_slot1;

  logic [1:0] w_count_nxt;
  T           w_slot0_nxt;
  T           w_slot1_nxt;
  logic       w_enq;
  logic       w_deq;

  assign o_in_ready  = (r_count != Q_TWO);
  assign w_enq       = i_in_valid && o_in_ready;
  assign w_deq       = r_out_valid && i_out_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_slot0;

  // Next occupancy and slot contents; clear wins over any handshake
  always_comb begin
    w_count_nxt = r_count;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    if (i_clear) begin
      w_count_nxt = Q_EMPTY;
    end else begin
      case (r_count)
        Q_EMPTY: begin
          if (w_enq) begin
            w_slot0_nxt = i_in_data;
            w_count_nxt = Q_ONE;
          end else begin
            w_count_nxt = Q_EMPTY;
          end
        end
        Q_ONE: begin
          if (w_enq && w_deq) begin
            // head leaves and the new record becomes the head
            w_slot0_nxt = i_in_data;
            w_count_nxt = Q_ONE;
          end else if (w_enq) begin
            w_slot1_nxt = i_in_data;
            w_count_nxt = Q_TWO;
          end else if (w_deq) begin
            w_count_nxt = Q_EMPTY;
          end else begin
            w_count_nxt = Q_ONE;
          end
        end
        Q_TWO: begin
          // no enqueue possible here: o_in_ready is low
          if (w_deq) begin
            w_slot0_nxt = r_slot1;
            w_count_nxt = Q_ONE;
          end else begin
            w_count_nxt = Q_TWO;
          end
        end
        default: begin
          w_count_nxt = Q_EMPTY;
        end
      endcase
    end
  end

  // Queue state registers; out_valid is kept as its own flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= Q_EMPTY;
      r_out_valid <= 1'b0;
      r_slot0     <= '0;
      r_slot1     <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != Q_EMPTY);
      r_slot0     <= w_slot0_nxt;
      r_slot1     <= w_slot1_nxt;
    end
  end

endmodule

// File: rtl/mem_resp_unit.sv
// -----------------------------------------------------------------------------
// mem_resp_unit
// Accepts in-order memory read responses, pops the matching entry of the
// outstanding-request address buffer for each, drops responses whose entry
// was invalidated by a flush, and forwards survivors through a registered
// 2-entry queue.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   flush       - pipeline flush (same cycle as the address buffer's flush)
//   bus         - memory response, address buffer and output channels
//   drop_cnt    - saturating count of dropped (stale) responses
//   orphan_err  - sticky: a response was presented with the buffer empty
// -----------------------------------------------------------------------------
module mem_resp_unit
  import mem_resp_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  mem_resp_unit_if.slave       bus,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 orphan_err
);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  error;
  } resp_w_t;

  logic                 w_q_in_ready;
  logic                 w_mem_rready;
  logic                 w_accept;
  logic                 w_keep;
  logic                 w_drop;
  logic                 w_orphan;
  resp_w_t              w_in;
  resp_w_t              w_out;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic                 r_orphan_err;

  // Ready depends only on the registered occupancy and the buffer state,
  // never on out_ready, so there is no combinational path across the unit.
  assign w_mem_rready = !bus.buf_empty && w_q_in_ready;
  assign w_accept     = bus.mem_rvalid && w_mem_rready;
  assign w_keep       = w_accept && bus.buf_valid && !flush;
  assign w_drop       = w_accept && !w_keep;
  assign w_orphan     = bus.mem_rvalid && bus.buf_empty;

  assign bus.mem_rready = w_mem_rready;
  assign bus.buf_rena   = w_accept;

  assign w_in = '{addr: bus.buf_rdata, data: bus.mem_rdata, error: bus.mem_rerror};

  mem_resp_unit_resp_queue #(
    .T (resp_w_t)
  ) u_resp_queue (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (flush),
    .i_in_valid  (w_keep),
    .o_in_ready  (w_q_in_ready),
    .i_in_data   (w_in),
    .o_out_valid (bus.out_valid),
    .i_out_ready (bus.out_ready),
    .o_out_data  (w_out)
  );

  assign bus.out_addr  = w_out.addr;
  assign bus.out_data  = w_out.data;
  assign bus.out_error = w_out.error;

  // Stale-response counter (saturating) and sticky orphan flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt   <= '0;
      r_orphan_err <= 1'b0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
      if (w_orphan) begin
        r_orphan_err <= 1'b1;
      end else begin
        r_orphan_err <= r_orphan_err;
      end
    end
  end

  assign drop_cnt   = r_drop_cnt;
  assign orphan_err = r_orphan_err;

endmodule

// File: tb/tb_mem_resp_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_unit
// Directed vector table, hand-written corner sequences, then a randomized
// run against a queue-based reference model of the unit and of the address
// buffer feeding it. The DUT is built with a 2-bit drop counter.
// -----------------------------------------------------------------------------
module tb_mem_resp_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 32;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] drop_cnt;
  logic          orphan_err;

  int n_vec  = 0;
  int n_miss = 0;

  mem_resp_unit_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  mem_resp_unit #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .drop_cnt   (drop_cnt),
    .orphan_err (orphan_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        bempty;
    logic [31:0] baddr;
    logic        bvalid;
    logic        fl;
    logic        ordy;
    logic        e_rready;
    logic        e_rena;
    logic        e_ovalid;
    logic [31:0] e_oaddr;
    logic [31:0] e_odata;
    logic        e_oerr;
    logic [1:0]  e_drop;
    logic        e_orph;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        v;
  } bent_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } mresp_t;

  vec_t   tbl [14];
  bent_t  bq [$];
  mresp_t mq [$];

  function automatic vec_t mk(input logic rv, input logic [31:0] rdata, input logic rerr,
                              input logic bempty, input logic [31:0] baddr, input logic bvalid,
                              input logic fl, input logic ordy,
                              input logic e_rready, input logic e_rena, input logic e_ovalid,
                              input logic [31:0] e_oaddr, input logic [31:0] e_odata,
                              input logic e_oerr, input logic [1:0] e_drop, input logic e_orph);
    vec_t v;
    v.rv = rv; v.rdata = rdata; v.rerr = rerr; v.bempty = bempty; v.baddr = baddr;
    v.bvalid = bvalid; v.fl = fl; v.ordy = ordy; v.e_rready = e_rready; v.e_rena = e_rena;
    v.e_ovalid = e_ovalid; v.e_oaddr = e_oaddr; v.e_odata = e_odata; v.e_oerr = e_oerr;
    v.e_drop = e_drop; v.e_orph = e_orph;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are sampled 1 time unit later
  task automatic drive(input logic rst, input logic fl, input logic rv, input logic [31:0] rdata,
                       input logic rerr, input logic bempty, input logic [31:0] baddr,
                       input logic bvalid, input logic ordy);
    @(negedge clk);
    reset          = rst;
    flush          = fl;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rdata;
    bus.mem_rerror = rerr;
    bus.buf_empty  = bempty;
    bus.buf_rdata  = baddr;
    bus.buf_valid  = bvalid;
    bus.out_ready  = ordy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic        rst, fl, rv, rerr, bempty, bvalid, ordy;
    logic [31:0] rdata, baddr, next_addr;
    logic        exp_rdy, acc, keep;
    int          m_drop;
    logic        m_orph;

    reset = 1'b1; flush = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.mem_rerror = 1'b0;
    bus.buf_empty = 1'b1; bus.buf_rdata = 32'h0; bus.buf_valid = 1'b0; bus.out_ready = 1'b1;

    // ---------------- directed table ----------------
    tbl[0]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 2'd0, 1'b0);
    tbl[1]  = mk(1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,    1'b0, 2'd0, 1'b0);
    tbl[2]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'hDEAD, 1'b0, 2'd0, 1'b0);
    tbl[3]  = mk(1'b1, 32'hA1,   1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,    1'b0, 2'd0, 1'b0);
    tbl[4]  = mk(1'b1, 32'hA2,   1'b0, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hA1,   1'b1, 2'd0, 1'b0);
    tbl[5]  = mk(1'b1, 32'hA3,   1'b0, 1'b0, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hA1,   1'b1, 2'd0, 1'b0);
    tbl[6]  = mk(1'b1, 32'hA3,   1'b0, 1'b0, 32'h208, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'hA1,   1'b1, 2'd0, 1'b0);
    tbl[7]  = mk(1'b1, 32'hA3,   1'b0, 1'b0, 32'h208, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h204, 32'hA2,   1'b0, 2'd0, 1'b0);
    tbl[8]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h208, 32'hA3,   1'b0, 2'd0, 1'b0);
    tbl[9]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 2'd0, 1'b0);
    tbl[10] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h300, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 2'd0, 1'b0);
    tbl[11] = mk(1'b1, 32'h11,   1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,    1'b0, 2'd0, 1'b0);
    tbl[12] = mk(1'b1, 32'h12,   1'b0, 1'b0, 32'h304, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,    1'b0, 2'd1, 1'b0);
    tbl[13] = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 2'd2, 1'b0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, tbl[i].fl, tbl[i].rv, tbl[i].rdata, tbl[i].rerr, tbl[i].bempty,
            tbl[i].baddr, tbl[i].bvalid, tbl[i].ordy);
      chk($sformatf("tbl%0d.mem_rready", i), bus.mem_rready, tbl[i].e_rready);
      chk($sformatf("tbl%0d.buf_rena", i),   bus.buf_rena,   tbl[i].e_rena);
      chk($sformatf("tbl%0d.out_valid", i),  bus.out_valid,  tbl[i].e_ovalid);
      if (tbl[i].e_ovalid) begin
        chk($sformatf("tbl%0d.out_addr", i),  bus.out_addr,  tbl[i].e_oaddr);
        chk($sformatf("tbl%0d.out_data", i),  bus.out_data,  tbl[i].e_odata);
        chk($sformatf("tbl%0d.out_error", i), bus.out_error, tbl[i].e_oerr);
      end
      chk($sformatf("tbl%0d.drop_cnt", i),   drop_cnt,   tbl[i].e_drop);
      chk($sformatf("tbl%0d.orphan_err", i), orphan_err, tbl[i].e_orph);
    end

    // ---------------- flush with a full queue ----------------
    drive(1'b0, 1'b0, 1'b1, 32'hB1, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0);
    chk("fullq.rready0", bus.mem_rready, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'hB2, 1'b0, 1'b0, 32'h404, 1'b1, 1'b0);
    chk("fullq.addr", bus.out_addr, 32'h400);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    chk("fullq.rready_full", bus.mem_rready, 1'b0);
    chk("fullq.valid_at_flush", bus.out_valid, 1'b1);
    chk("fullq.data_at_flush", bus.out_data, 32'hB1);
    idle();
    chk("fullq.valid_after_flush", bus.out_valid, 1'b0);
    // accept in a flush cycle is a drop even though buf_valid=1
    drive(1'b0, 1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h500, 1'b1, 1'b1);
    chk("flushacc.rena", bus.buf_rena, 1'b1);
    idle();
    chk("flushacc.valid", bus.out_valid, 1'b0);
    chk("flushacc.drop", drop_cnt, 2'd3);
    drive(1'b0, 1'b0, 1'b1, 32'hC1, 1'b0, 1'b0, 32'h504, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'hC2, 1'b0, 1'b0, 32'h508, 1'b0, 1'b1);
    idle();
    chk("drop_hold_sat", drop_cnt, 2'd3);

    // ---------------- saturation from reset ----------------
    do_reset();
    idle();
    chk("sat.reset_drop", drop_cnt, 2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hD0 + i, 1'b0, 1'b0, 32'h700 + 4 * i, 1'b0, 1'b1);
    end
    idle();
    chk("sat.drop5", drop_cnt, 2'd3);

    // ---------------- orphan response ----------------
    drive(1'b0, 1'b0, 1'b1, 32'hE0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    chk("orphan.rready", bus.mem_rready, 1'b0);
    chk("orphan.rena", bus.buf_rena, 1'b0);
    chk("orphan.before", orphan_err, 1'b0);
    idle();
    chk("orphan.set", orphan_err, 1'b1);
    idle(); idle(); idle();
    chk("orphan.sticky", orphan_err, 1'b1);

    // ---------------- reset mid-transfer ----------------
    drive(1'b0, 1'b0, 1'b1, 32'hF0, 1'b1, 1'b0, 32'h600, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hF1, 1'b0, 1'b0, 32'h604, 1'b1, 1'b0);
    chk("midrst.valid_before", bus.out_valid, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'hF2, 1'b0, 1'b0, 32'h608, 1'b1, 1'b0);
    chk("midrst.rready_eq", bus.mem_rready, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("midrst.out_valid", bus.out_valid, 1'b0);
    chk("midrst.out_addr", bus.out_addr, 32'h0);
    chk("midrst.out_data", bus.out_data, 32'h0);
    chk("midrst.out_error", bus.out_error, 1'b0);
    chk("midrst.drop", drop_cnt, 2'd0);
    chk("midrst.orphan", orphan_err, 1'b0);
    chk("midrst.rready", bus.mem_rready, 1'b0);
    chk("midrst.rena", bus.buf_rena, 1'b0);

    // ---------------- randomized run vs. reference model ----------------
    do_reset();
    bq.delete(); mq.delete();
    m_drop = 0; m_orph = 1'b0; next_addr = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      fl  = !rst && ($urandom_range(0, 15) == 0);
      if (!fl && bq.size() < 4 && $urandom_range(0, 1) == 1) begin
        bq.push_back('{addr: next_addr, v: 1'b1});
        next_addr = next_addr + 32'd4;
      end
      bempty = (bq.size() == 0);
      baddr  = bempty ? 32'($urandom) : bq[0].addr;
      bvalid = bempty ? 1'($urandom_range(0, 1)) : bq[0].v;
      rv     = bempty ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) != 0);
      rdata  = 32'($urandom);
      rerr   = ($urandom_range(0, 7) == 0);
      ordy   = ($urandom_range(0, 3) != 0);
      drive(rst, fl, rv, rdata, rerr, bempty, baddr, bvalid, ordy);

      exp_rdy = !bempty && (mq.size() < 2);
      acc     = rv && exp_rdy;
      chk("rnd.mem_rready", bus.mem_rready, exp_rdy);
      chk("rnd.buf_rena", bus.buf_rena, acc);
      chk("rnd.out_valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("rnd.out_addr", bus.out_addr, mq[0].a);
        chk("rnd.out_data", bus.out_data, mq[0].d);
        chk("rnd.out_error", bus.out_error, mq[0].e);
      end
      chk("rnd.drop_cnt", drop_cnt, m_drop);
      chk("rnd.orphan_err", orphan_err, m_orph);

      @(posedge clk);
      if (rst) begin
        bq.delete(); mq.delete();
        m_drop = 0; m_orph = 1'b0;
      end else begin
        keep = acc && bvalid && !fl;
        if (acc) begin
          void'(bq.pop_front());
          if (!keep && m_drop < 3) m_drop++;
        end
        if (fl) begin
          mq.delete();
          foreach (bq[i]) bq[i].v = 1'b0;
        end else begin
          if (mq.size() != 0 && ordy) void'(mq.pop_front());
          if (keep) mq.push_back('{a: baddr, d: rdata, e: rerr});
        end
        if (rv && bempty) m_orph = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_resp_unit.md
# mem_resp_unit

Response-side companion to the outstanding-request address buffer in the load/fetch path. It accepts in-order memory read responses, pops the matching address entry from the buffer for each one, and drops responses whose entry was invalidated by a flush. Surviving responses go to the pipeline through a registered 2-entry output queue under valid/ready handshaking. It sits between the memory interface response channel and the core's writeback/fetch consumer.

## Interface
- DATA_WIDTH, 32, memory response data width
- TAG_WIDTH, 32, width of an address-buffer entry (request address)
- CNT_WIDTH, 8, width of the dropped-response counter
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; same cycle as the address buffer's flush
- mem_rvalid  in  1  memory response valid
- mem_rready  out  1  response accepted when mem_rvalid && mem_rready
- mem_rdata  in  DATA_WIDTH  response data
- mem_rerror  in  1  bus error for this response
- buf_rena  out  1  pop request to address buffer
- buf_rdata  in  TAG_WIDTH  head entry address
- buf_valid  in  1  head entry not invalidated by flush
- buf_empty  in  1  address buffer empty
- out_valid  out  1  output queue head valid
- out_ready  in  1  consumer takes head when out_valid && out_ready
- out_addr  out  TAG_WIDTH  request address of head
- out_data  out  DATA_WIDTH  response data of head
- out_error  out  1  bus error of head
- drop_cnt  out  CNT_WIDTH  saturating count of dropped (stale) responses
- orphan_err  out  1  sticky: response presented while address buffer empty

## Operation
- Accept = mem_rvalid && mem_rready. mem_rready = !buf_empty && (count < 2); count is the registered queue occupancy, so there is no combinational path from out_ready to mem_rready.
- buf_rena = accept (pop the head in the accept cycle; combinational from mem_rvalid).
- On accept with buf_valid=1 and flush=0: enqueue {buf_rdata, mem_rdata, mem_rerror}.
- On accept with buf_valid=0 or flush=1: discard; drop_cnt += 1, saturating at all-ones.
- Queue states EMPTY(0), ONE(1), TWO(2). Enqueue only -> +1; dequeue (out_valid && out_ready) only -> -1; both in one cycle -> count unchanged, order preserved (FIFO).
- flush: next cycle count=0 and out_valid=0. A dequeue in the flush cycle still completes. Any accept in the flush cycle is a drop.
- mem_rvalid=1 while buf_empty=1: response is not accepted and orphan_err is set. orphan_err clears only on reset.
- out_* hold stable while out_valid && !out_ready.

## Timing
- Reset: count=0, out_valid=0, out_addr/out_data=0, out_error=0, drop_cnt=0, orphan_err=0. mem_rready and buf_rena follow their equations (0 while buf_empty=1).
- Latency: accept in cycle N -> out_valid=1 in cycle N+1.
- Throughput: 1 response/cycle sustained while out_ready=1.
- Reset asserted mid-stream overrides flush and all handshakes. Queue contents are lost; the address buffer is reset by the same signal.
- drop_cnt and orphan_err update on the clock edge after the triggering event.

## Structure
- Shared memory-interface package: typedef struct resp_t {addr, data, error}, and the default width constants.
- One sub-module, resp_queue: a 2-entry registered FIFO of resp_t with count, in/out handshakes and a synchronous clear (used for flush). The top level holds the accept/drop logic, counters and the orphan flag.

## Test plan
- Basic: buffer holds A=0x100 (valid); response data 0xDEAD, rerror=0 -> buf_rena pulses once; next cycle out_valid=1, out_addr=0x100, out_data=0xDEAD.
- Backpressure: out_ready=0 with 3 responses offered -> two are queued, mem_rready=0 on the third. Release out_ready -> outputs appear in order, then the third is accepted.
- Flush drop: 2 entries issued, flush, 2 responses arrive (buf_valid=0) -> both popped, no out_valid, drop_cnt=2.
- Flush with queue full: count=2, flush with out_ready=1 -> one dequeue completes, then out_valid=0 next cycle. A response accepted in the flush cycle -> drop_cnt+1.
- Orphan: buf_empty=1, mem_rvalid=1 -> mem_rready=0, buf_rena=0, orphan_err=1 next cycle, sticky until reset.
- Saturation and reset: CNT_WIDTH=2, 5 stale responses -> drop_cnt=3. Reset mid-transfer -> all outputs at reset values next cycle.
